uart_pixel_framer: RTL and testbench

- Sits between the UART receive path (`rx_rd_data`/`rx_valid`) and the Canny edge pipeline.
- Parses a small frame header from the byte stream, then forwards exactly width×height pixel bytes.
- Tags each forwarded pixel with start-of-frame, end-of-line and end-of-frame markers.
- Drops bytes outside a frame and recovers from truncated frames via an inter-byte timeout.

---
 rtl/uart_pixel_framer.sv | 189 ++++++++++++++++++
 tb/tb_uart_pixel_framer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pixel_framer.sv
// uart_pixel_framer: parses a SYNC/W/H header from the UART byte stream and
// forwards exactly W*H pixel bytes, tagged with sof/eol/eof markers.
// Bytes outside a frame are dropped; a stalled frame is aborted by an
// inter-byte timeout so the parser always returns to hunting for sync.
module uart_pixel_framer #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DIM_W       = 16,
  parameter int unsigned MAX_DIM     = 1024,
  parameter logic [DATA_W-1:0] SYNC_BYTE = 'hA5,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] pixel_out,
  output logic              pixel_out_valid,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic [DIM_W-1:0]  img_width,
  output logic [DIM_W-1:0]  img_height,
  output logic              frame_busy,
  output logic              hdr_err,
  output logic              timeout_err
);

  localparam int unsigned LP_HDR_W = 2 * DATA_W;
  localparam int unsigned LP_TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [LP_HDR_W-1:0] LP_MAX_HDR = LP_HDR_W'(MAX_DIM);
  localparam logic [LP_TO_W-1:0]  LP_TO_LAST = LP_TO_W'(TIMEOUT_CYC - 1);
  localparam logic [LP_TO_W-1:0]  LP_TO_ONE  = LP_TO_W'(1);
  localparam logic [DIM_W-1:0]    LP_DIM_ONE = DIM_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR0   = 3'd1,
    ST_HDR1   = 3'd2,
    ST_HDR2   = 3'd3,
    ST_HDR3   = 3'd4,
    ST_STREAM = 3'd5
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_w_hi;
  logic [DATA_W-1:0]   r_w_lo;
  logic [DATA_W-1:0]   r_h_hi;
  logic [DIM_W-1:0]    r_col;
  logic [DIM_W-1:0]    r_row;
  logic [LP_TO_W-1:0]  r_to_cnt;

  logic [DATA_W-1:0]   r_pix;
  logic                r_pix_vld;
  logic                r_sof;
  logic                r_eol;
  logic                r_eof;
  logic [DIM_W-1:0]    r_img_width;
  logic [DIM_W-1:0]    r_img_height;
  logic                r_busy;
  logic                r_hdr_err;
  logic                r_timeout_err;

  logic [LP_HDR_W-1:0] w_hdr_w;
  logic [LP_HDR_W-1:0] w_hdr_h;
  logic                w_hdr_ok;
  logic                w_last_col;
  logic                w_last_row;

  // Header is validated while the H_lo byte is still on the input bus.
  assign w_hdr_w  = {r_w_hi, r_w_lo};
  assign w_hdr_h  = {r_h_hi, in_data};
  assign w_hdr_ok = (w_hdr_w != '0) && (w_hdr_w <= LP_MAX_HDR) &&
                    (w_hdr_h != '0) && (w_hdr_h <= LP_MAX_HDR);

  // Latched dimensions are >= 1 by construction, so "-1" cannot underflow.
  assign w_last_col = (r_col == (r_img_width  - LP_DIM_ONE));
  assign w_last_row = (r_row == (r_img_height - LP_DIM_ONE));

  // Framing FSM: header parse, pixel forwarding with markers, timeout abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_col         <= '0;
      r_row         <= '0;
      r_to_cnt      <= '0;
      r_pix         <= '0;
      r_pix_vld     <= 1'b0;
      r_sof         <= 1'b0;
      r_eol         <= 1'b0;
      r_eof         <= 1'b0;
      r_img_width   <= '0;
      r_img_height  <= '0;
      r_busy        <= 1'b0;
      r_hdr_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      // Per-pixel qualifiers and error flags are single-cycle pulses.
      r_pix_vld     <= 1'b0;
      r_sof         <= 1'b0;
      r_eol         <= 1'b0;
      r_eof         <= 1'b0;
      r_hdr_err     <= 1'b0;
      r_timeout_err <= 1'b0;

      if (r_state == ST_IDLE) begin
        r_to_cnt <= '0;
        if (in_valid && (in_data == SYNC_BYTE)) begin
          r_state <= ST_HDR0;
          r_busy  <= 1'b1;
        end
      end else if (in_valid) begin
        // A byte arriving on the timeout cycle is consumed; no abort.
        r_to_cnt <= '0;
        case (r_state)
          ST_HDR0: begin
            r_w_hi  <= in_data;
            r_state <= ST_HDR1;
          end
          ST_HDR1: begin
            r_w_lo  <= in_data;
            r_state <= ST_HDR2;
          end
          ST_HDR2: begin
            r_h_hi  <= in_data;
            r_state <= ST_HDR3;
          end
          ST_HDR3: begin
            if (w_hdr_ok) begin
              r_img_width  <= DIM_W'(w_hdr_w);
              r_img_height <= DIM_W'(w_hdr_h);
              r_col        <= '0;
              r_row        <= '0;
              r_state      <= ST_STREAM;
            end else begin
              r_hdr_err <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end
          ST_STREAM: begin
            r_pix     <= in_data;
            r_pix_vld <= 1'b1;
            r_sof     <= (r_col == '0) && (r_row == '0);
            r_eol     <= w_last_col;
            r_eof     <= w_last_col && w_last_row;
            if (w_last_col) begin
              r_col <= '0;
              if (w_last_row) begin
                r_row   <= '0;
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end else begin
                r_row <= r_row + LP_DIM_ONE;
              end
            end else begin
              r_col <= r_col + LP_DIM_ONE;
            end
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end else if (r_to_cnt == LP_TO_LAST) begin
        r_timeout_err <= 1'b1;
        r_busy        <= 1'b0;
        r_to_cnt      <= '0;
        r_col         <= '0;
        r_row         <= '0;
        r_state       <= ST_IDLE;
      end else begin
        r_to_cnt <= r_to_cnt + LP_TO_ONE;
      end
    end
  end

  assign pixel_out       = r_pix;
  assign pixel_out_valid = r_pix_vld;
  assign sof             = r_sof;
  assign eol             = r_eol;
  assign eof             = r_eof;
  assign img_width       = r_img_width;
  assign img_height      = r_img_height;
  assign frame_busy      = r_busy;
  assign hdr_err         = r_hdr_err;
  assign timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_uart_pixel_framer.sv
// Directed bench for uart_pixel_framer: header parsing, pixel markers,
// header rejection, timeout abort, reset mid-frame and back-to-back frames.
module tb_uart_pixel_framer;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [7:0]  pixel_out;
  logic        pixel_out_valid;
  logic        sof;
  logic        eol;
  logic        eof;
  logic [15:0] img_width;
  logic [15:0] img_height;
  logic        frame_busy;
  logic        hdr_err;
  logic        timeout_err;

  uart_pixel_framer #(
    .DATA_W      (8),
    .DIM_W       (16),
    .MAX_DIM     (1024),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .pixel_out       (pixel_out),
    .pixel_out_valid (pixel_out_valid),
    .sof             (sof),
    .eol             (eol),
    .eof             (eof),
    .img_width       (img_width),
    .img_height      (img_height),
    .frame_busy      (frame_busy),
    .hdr_err         (hdr_err),
    .timeout_err     (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       l;
    logic       f;
    logic       b;
    int         cyc;
  } out_t;

  out_t q[$];
  int   cyc      = 0;
  int   n_chk    = 0;
  int   n_pass   = 0;
  int   hdr_cnt  = 0;
  int   to_cnt   = 0;
  int   to_cyc   = -1;
  int   bad_flag = 0;
  int   send_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs sampled on the falling edge, half a cycle after they change.
  always @(negedge clk) begin
    if (pixel_out_valid)
      q.push_back('{d: pixel_out, s: sof, l: eol, f: eof, b: frame_busy, cyc: cyc});
    if (!pixel_out_valid && (sof || eol || eof)) bad_flag++;
    if (hdr_err) hdr_cnt++;
    if (timeout_err) begin
      to_cnt++;
      to_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic chk_px(input string tag, input int idx, input logic [7:0] d,
                        input logic s, input logic l, input logic f, input logic b);
    logic [31:0] got;
    if (idx < q.size()) got = {20'h0, q[idx].d, q[idx].s, q[idx].l, q[idx].f, q[idx].b};
    else                got = 32'hDEAD_BEEF;
    chk($sformatf("%s[%0d]", tag, idx), got, {20'h0, d, s, l, f, b});
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    send_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_hdr(input logic [15:0] w, input logic [15:0] h);
    send(8'hA5); send(w[15:8]); send(w[7:0]); send(h[15:8]); send(h[7:0]);
  endtask

  logic [7:0] ff_px [8];
  logic       ff_s  [8];
  logic       ff_l  [8];
  logic       ff_f  [8];
  logic       ff_b  [8];
  int         t0;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    idle(3);
    chk("reset_outs", {pixel_out, pixel_out_valid, sof, eol, eof, frame_busy, hdr_err, timeout_err}, 32'h0);
    chk("reset_dims", {img_width, img_height}, 32'h0);
    rst = 1'b0;
    idle(2);

    // 4x2 frame, contiguous bytes.
    q.delete();
    send_hdr(16'd4, 16'd2);
    for (int i = 0; i < 8; i++) begin
      send(8'h10 + 8'(i));
      if (i == 0) t0 = send_cyc;
    end
    idle(3);
    chk("a_dims", {img_width, img_height}, {16'd4, 16'd2});
    chk("a_count", q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk_px("a_px", i, 8'h10 + 8'(i), i == 0, (i == 3) || (i == 7), i == 7, i != 7);
      if (i < q.size()) chk($sformatf("a_lat[%0d]", i), q[i].cyc - (t0 + i), 1);
    end

    // Garbage then a 1x1 frame.
    q.delete();
    send(8'h00); send(8'hFF); send(8'h3C);
    send_hdr(16'd1, 16'd1);
    send(8'h99);
    idle(3);
    chk("b_count", q.size(), 1);
    chk_px("b_px", 0, 8'h99, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("b_dims", {img_width, img_height}, {16'd1, 16'd1});

    // Header rejection and MAX_DIM acceptance.
    q.delete();
    hdr_cnt = 0;
    send_hdr(16'd0, 16'd5);
    idle(2);
    chk("c_hdr_w0", hdr_cnt, 1);
    chk("c_busy_w0", frame_busy, 0);
    chk("c_dims_kept", {img_width, img_height}, {16'd1, 16'd1});
    send_hdr(16'd1024, 16'd1);
    idle(2);
    chk("c_hdr_1024", hdr_cnt, 1);
    chk("c_busy_1024", frame_busy, 1);
    chk("c_dims_1024", {img_width, img_height}, {16'd1024, 16'd1});
    for (int i = 0; i < 1024; i++) send(8'(i));
    idle(2);
    chk("c_count_1024", q.size(), 1024);
    chk_px("c_px", 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_px("c_px", 1023, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
    send_hdr(16'd1025, 16'd1);
    idle(2);
    chk("c_hdr_1025", hdr_cnt, 2);
    chk("c_dims_after", {img_width, img_height}, {16'd1024, 16'd1});

    // Timeout abort after 3 of 4 pixels.
    q.delete();
    to_cnt = 0;
    send_hdr(16'd2, 16'd2);
    send(8'h01); send(8'h02); send(8'h03);
    t0 = send_cyc;
    idle(80);
    chk("d_to_count", to_cnt, 1);
    chk("d_to_delay", to_cyc - t0, 65);
    chk("d_busy", frame_busy, 0);
    chk("d_count", q.size(), 3);
    chk_px("d_px", 2, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
    q.delete();
    send_hdr(16'd2, 16'd2);
    send(8'h04); send(8'h05); send(8'h06); send(8'h07);
    idle(3);
    chk("d2_count", q.size(), 4);
    chk_px("d2_px", 0, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_px("d2_px", 1, 8'h05, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_px("d2_px", 3, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("d2_to_count", to_cnt, 1);

    // Reset in the middle of a 4x4 frame.
    hdr_cnt = 0;
    send_hdr(16'd4, 16'd4);
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i));
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("e_rst_outs", {pixel_out, pixel_out_valid, sof, eol, eof, frame_busy, hdr_err, timeout_err}, 32'h0);
    chk("e_rst_dims", {img_width, img_height}, 32'h0);
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 11; i++) send(8'h20 + 8'(i));
    idle(3);
    chk("e_drop", q.size(), 0);
    chk("e_busy", frame_busy, 0);
    send_hdr(16'd2, 16'd2);
    send(8'h61); send(8'h62); send(8'h63); send(8'h64);
    idle(3);
    chk("e_count", q.size(), 4);
    chk_px("e_px", 0, 8'h61, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_px("e_px", 3, 8'h64, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("e_err", hdr_cnt + to_cnt, 1);

    // Two 2x2 frames back-to-back, with A5 used as pixel data.
    q.delete();
    ff_px = '{8'hA5, 8'h11, 8'h22, 8'hA5, 8'h33, 8'hA5, 8'hA5, 8'h44};
    ff_s  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ff_l  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ff_f  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    ff_b  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    send_hdr(16'd2, 16'd2);
    for (int i = 0; i < 4; i++) send(ff_px[i]);
    send_hdr(16'd2, 16'd2);
    for (int i = 4; i < 8; i++) send(ff_px[i]);
    idle(3);
    chk("f_count", q.size(), 8);
    for (int i = 0; i < 8; i++)
      chk_px("f_px", i, ff_px[i], ff_s[i], ff_l[i], ff_f[i], ff_b[i]);

    chk("flag_qual", bad_flag, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
